snitch_barrier_handshake: RTL and testbench

Per-core front end to the cluster hardware barrier.
- Accepts one barrier request per core over a valid/ready channel and emits a single-cycle arrival pulse to the barrier.
- Holds each core's response until the barrier's one-cycle release pulse, then returns a valid/ready response.
- Sits between the cluster peripheral/request path and the barrier synchroniser; one instance per cluster.

---
 rtl/snitch_barrier_handshake.sv | 135 +++++++++++++
 tb/tb_snitch_barrier_handshake.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/snitch_barrier_handshake.sv
// snitch_barrier_handshake
//   Per-core front end to the cluster hardware barrier. Each core enters the
//   barrier over a valid/ready request channel. The block emits a one-cycle
//   arrival pulse for that core, then holds the core until the barrier's
//   one-cycle release pulse. It then returns a valid/ready response.
//   Every output is decoded from registered state only.
//
// Parameters
//   NrCores       number of cores (must be >= 1)
//   WaitCntWidth  width of the per-core wait-cycle counter
//
// Ports
//   clk_i          clock
//   rst_i          asynchronous, active-high reset
//   req_valid_i    [NrCores]   core i requests barrier entry
//   req_ready_o    [NrCores]   core i request accepted (core idle)
//   rsp_valid_o    [NrCores]   barrier passed, response pending for core i
//   rsp_ready_i    [NrCores]   core i consumes response
//   arrive_o       [NrCores]   one-cycle arrival pulse to the barrier
//   release_i                  one-cycle release pulse from the barrier
//   episode_o      [16]        completed barrier episodes (wraps)
//   wait_cycles_o  [NrCores*WaitCntWidth] per-core wait time of last episode
//
// Optional feature macro: SNITCH_BARRIER_PERF_EN
//   Defined  : per-core saturating wait counters drive wait_cycles_o.
//   Undefined: wait_cycles_o is tied to zero and no counter flops exist.

module snitch_barrier_handshake #(
    parameter int unsigned NrCores      = 1,
    parameter int unsigned WaitCntWidth = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NrCores-1:0]              req_valid_i,
    output logic [NrCores-1:0]              req_ready_o,
    output logic [NrCores-1:0]              rsp_valid_o,
    input  logic [NrCores-1:0]              rsp_ready_i,
    output logic [NrCores-1:0]              arrive_o,
    input  logic                            release_i,
    output logic [15:0]                     episode_o,
    output logic [NrCores*WaitCntWidth-1:0] wait_cycles_o
);

    typedef enum logic [1:0] {
        IDLE,
        ARRIVE,
        WAIT,
        RESP
    } state_e;

    state_e state_q [NrCores];
    state_e state_d [NrCores];

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NrCores; i++) begin
                state_q[i] <= IDLE;
            end
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, one independent FSM per core
    always_comb begin
        for (int unsigned i = 0; i < NrCores; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                IDLE:    if (req_valid_i[i]) state_d[i] = ARRIVE;
                ARRIVE:  state_d[i] = WAIT;
                WAIT:    if (release_i) state_d[i] = RESP;
                RESP:    if (rsp_ready_i[i]) state_d[i] = IDLE;
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // Output decode from registered state only
    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        arrive_o    = '0;
        for (int unsigned i = 0; i < NrCores; i++) begin
            req_ready_o[i] = (state_q[i] == IDLE);
            arrive_o[i]    = (state_q[i] == ARRIVE);
            rsp_valid_o[i] = (state_q[i] == RESP);
        end
    end

    // Episode counter: every release pulse completes one episode
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            episode_o <= '0;
        end else if (release_i) begin
            episode_o <= episode_o + 16'd1;
        end
    end

`ifdef SNITCH_BARRIER_PERF_EN
    logic [WaitCntWidth-1:0]         cnt_q [NrCores];
    logic [NrCores*WaitCntWidth-1:0] wait_q;

    function automatic logic [WaitCntWidth-1:0] sat_inc(input logic [WaitCntWidth-1:0] v);
        return (&v) ? v : v + WaitCntWidth'(1);
    endfunction

    // The ARRIVE cycle preloads 1, so the latched value covers the cycles
    // from acceptance up to and including the release cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NrCores; i++) begin
                cnt_q[i] <= '0;
            end
            wait_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NrCores; i++) begin
                if (state_q[i] == ARRIVE) begin
                    cnt_q[i] <= WaitCntWidth'(1);
                end else if (state_q[i] == WAIT) begin
                    cnt_q[i] <= sat_inc(cnt_q[i]);
                    if (release_i) begin
                        wait_q[i*WaitCntWidth +: WaitCntWidth] <= sat_inc(cnt_q[i]);
                    end
                end
            end
        end
    end

    assign wait_cycles_o = wait_q;
`else
    assign wait_cycles_o = '0;
`endif

endmodule

// File: tb/tb_snitch_barrier_handshake.sv
// Self-checking bench for snitch_barrier_handshake with NrCores=4.
// A table of per-cycle vectors covers the basic episode, spurious releases,
// and the back-to-back corner. Hand-written sequences cover staggered
// arrivals, back-pressure, reset mid-WAIT and episode counter wrap.

module tb_snitch_barrier_handshake;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [N-1:0]   arrive;
    logic           release_p;
    logic [15:0]    episode;
    logic [N*W-1:0] wait_cycles;

    snitch_barrier_handshake #(
        .NrCores      (N),
        .WaitCntWidth (W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .arrive_o      (arrive),
        .release_i     (release_p),
        .episode_o     (episode),
        .wait_cycles_o (wait_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  req_valid;
        logic [3:0]  rsp_ready;
        logic        rel;
        logic [3:0]  e_req_ready;
        logic [3:0]  e_rsp_valid;
        logic [3:0]  e_arrive;
        logic [15:0] e_episode;
    } vec_t;

    vec_t vecs [15];
    int   t_acc [4];
    int   arr_cnt [4];

    initial begin
        // Cycle-by-cycle vectors: inputs for the cycle, outputs expected in it
        vecs[0]  = '{4'hF, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0, 16'd0}; // all request
        vecs[1]  = '{4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'hF, 16'd0}; // arrive pulses
        vecs[2]  = '{4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 16'd0}; // release
        vecs[3]  = '{4'h0, 4'hF, 1'b0, 4'h0, 4'hF, 4'h0, 16'd1}; // responses
        vecs[4]  = '{4'h0, 4'h0, 1'b1, 4'hF, 4'h0, 4'h0, 16'd1}; // release in IDLE
        vecs[5]  = '{4'h1, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0, 16'd2}; // core0 request
        vecs[6]  = '{4'h0, 4'h0, 1'b0, 4'hE, 4'h0, 4'h1, 16'd2};
        vecs[7]  = '{4'h0, 4'h0, 1'b1, 4'hE, 4'h0, 4'h0, 16'd2};
        vecs[8]  = '{4'h1, 4'h0, 1'b1, 4'hE, 4'h1, 4'h0, 16'd3}; // release+req in RESP
        vecs[9]  = '{4'h1, 4'h1, 1'b0, 4'hE, 4'h1, 4'h0, 16'd4}; // handshake + req
        vecs[10] = '{4'h1, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0, 16'd4}; // accepted now
        vecs[11] = '{4'h0, 4'h0, 1'b0, 4'hE, 4'h0, 4'h1, 16'd4};
        vecs[12] = '{4'h0, 4'h0, 1'b1, 4'hE, 4'h0, 4'h0, 16'd4};
        vecs[13] = '{4'h0, 4'h1, 1'b0, 4'hE, 4'h1, 4'h0, 16'd5};
        vecs[14] = '{4'h0, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0, 16'd5};
        t_acc = '{0, 5, 9, 20};

        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        release_p = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'hF);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_arrive",    32'(arrive),    32'h0);
        check("reset_episode",   32'(episode),   32'h0);
        check("reset_wait",      32'(|wait_cycles), 32'h0);
        next_cycle();
        rst = 1'b0;

        // Table-driven vectors
        for (int v = 0; v < 15; v++) begin
            req_valid = vecs[v].req_valid;
            rsp_ready = vecs[v].rsp_ready;
            release_p = vecs[v].rel;
            @(negedge clk);
            check($sformatf("vec%0d_req_ready", v), 32'(req_ready), 32'(vecs[v].e_req_ready));
            check($sformatf("vec%0d_rsp_valid", v), 32'(rsp_valid), 32'(vecs[v].e_rsp_valid));
            check($sformatf("vec%0d_arrive", v),    32'(arrive),    32'(vecs[v].e_arrive));
            check($sformatf("vec%0d_episode", v),   32'(episode),   32'(vecs[v].e_episode));
`ifndef SNITCH_BARRIER_PERF_EN
            check($sformatf("vec%0d_wait_zero", v), 32'(|wait_cycles), 32'h0);
`endif
            next_cycle();
        end

        // Staggered arrivals at cycles 0, 5, 9, 20; release in cycle 22
        arr_cnt = '{0, 0, 0, 0};
        for (int c = 0; c < 24; c++) begin
            for (int i = 0; i < N; i++) req_valid[i] = (c == t_acc[i]);
            release_p = (c == 22);
            rsp_ready = '0;
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (arrive[i]) arr_cnt[i]++;
                check($sformatf("stag_c%0d_arrive%0d", c, i), 32'(arrive[i]), 32'(c == t_acc[i] + 1));
            end
            check($sformatf("stag_c%0d_rsp_valid", c), 32'(rsp_valid), (c == 23) ? 32'hF : 32'h0);
            next_cycle();
        end
        for (int i = 0; i < N; i++) check($sformatf("stag_arrive_count%0d", i), 32'(arr_cnt[i]), 32'd1);
        check("stag_episode", 32'(episode), 32'd6);
`ifdef SNITCH_BARRIER_PERF_EN
        check("perf_wait0", wait_cycles[0*W +: W], 32'd22);
        check("perf_wait1", wait_cycles[1*W +: W], 32'd17);
        check("perf_wait2", wait_cycles[2*W +: W], 32'd13);
        check("perf_wait3", wait_cycles[3*W +: W], 32'd2);
`else
        check("stag_wait_zero", 32'(|wait_cycles), 32'h0);
`endif

        // Back-pressure: core 2 withholds rsp_ready for 10 cycles
        req_valid = '0;
        release_p = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rsp_ready = 4'b1011;
            @(negedge clk);
            if (k == 0) begin
                check("bp_first_rsp_valid", 32'(rsp_valid), 32'hF);
            end else begin
                check($sformatf("bp%0d_rsp_valid", k), 32'(rsp_valid), 32'b0100);
                check($sformatf("bp%0d_req_ready", k), 32'(req_ready), 32'b1011);
            end
            next_cycle();
        end
        rsp_ready = 4'b0100;
        @(negedge clk);
        check("bp_release_rsp_valid", 32'(rsp_valid), 32'b0100);
        next_cycle();
        rsp_ready = '0;
        @(negedge clk);
        check("bp_done_rsp_valid", 32'(rsp_valid), 32'h0);
        check("bp_done_req_ready", 32'(req_ready), 32'hF);
`ifdef SNITCH_BARRIER_PERF_EN
        check("perf_hold2", wait_cycles[2*W +: W], 32'd13);
`endif
        next_cycle();

        // Reset asserted while all cores sit in WAIT
        req_valid = 4'hF;
        next_cycle();
        req_valid = '0;
        next_cycle();
        check("pre_rst_in_wait", 32'(req_ready | arrive | rsp_valid), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_req_ready", 32'(req_ready), 32'hF);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_mid_arrive",    32'(arrive),    32'h0);
        check("rst_mid_episode",   32'(episode),   32'h0);
        check("rst_mid_wait",      32'(|wait_cycles), 32'h0);
        next_cycle();
        rst       = 1'b0;
        release_p = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("rst_stale%0d_rsp_valid", k), 32'(rsp_valid), 32'h0);
            check($sformatf("rst_stale%0d_req_ready", k), 32'(req_ready), 32'hF);
            next_cycle();
            release_p = 1'b0;
        end

        // Episode counter wrap
        rst = 1'b1;
        next_cycle();
        rst       = 1'b0;
        release_p = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        @(negedge clk);
        check("wrap_ffff", 32'(episode), 32'hFFFF);
        next_cycle();
        release_p = 1'b0;
        @(negedge clk);
        check("wrap_zero", 32'(episode), 32'h0);
        check("wrap_req_ready", 32'(req_ready), 32'hF);
`ifndef SNITCH_BARRIER_PERF_EN
        check("wrap_wait_zero", 32'(|wait_cycles), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
